// File: rtl/train_led_chain.sv
// rtl/train_led_chain.sv - pulse-width-coded LED chain node: decode, latch on gap, forward the rest
// Optional PWM LED drive when TRAIN_LED_CHAIN_PWM_EN is defined; otherwise led is the duty MSB.
module train_led_chain #(
    parameter int NUM_CH       = 3,
    parameter int BITS         = 8,
    parameter int T1_MIN       = 6,
    parameter int RESET_CYCLES = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              din,
    output logic              dout,
    output logic [NUM_CH-1:0] led,
    output logic              frame
);
    localparam int TOTAL = NUM_CH * BITS;
    localparam int CW    = $clog2(TOTAL + 1);
    localparam int HW    = $clog2(T1_MIN + 1);
    localparam int LW    = $clog2(RESET_CYCLES + 1);

    localparam logic [CW-1:0] TOTAL_C = CW'(TOTAL);
    localparam logic [HW-1:0] HI_MAX  = HW'(T1_MIN);
    localparam logic [LW-1:0] LO_MAX  = LW'(RESET_CYCLES);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_HIGH = 2'd1;
    localparam logic [1:0] S_LOW  = 2'd2;

    logic [1:0]       r_sync;
    logic [1:0]       r_state;
    logic [HW-1:0]    r_hi_cnt;
    logic [LW-1:0]    r_lo_cnt;
    logic [CW-1:0]    r_bit_cnt;
    logic [TOTAL-1:0] r_shift;
    logic [TOTAL-1:0] r_duty;
    logic             r_fwd;
    logic             r_dout;
    logic             r_frame;

    logic w_din_s;
    logic w_fall;
    logic w_bit;
    logic w_gap;
    logic w_full;

    assign w_din_s = r_sync[1];
    assign w_fall  = (r_state == S_HIGH) && !w_din_s;
    assign w_bit   = (r_hi_cnt >= HI_MAX);
    // Fires on the RESET_CYCLES-th low cycle only; IDLE never re-fires it.
    assign w_gap   = (r_state == S_LOW) && !w_din_s && (r_lo_cnt == LO_MAX - LW'(1));
    assign w_full  = (r_bit_cnt == TOTAL_C);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync   <= 2'b00;
            r_state  <= S_IDLE;
            r_hi_cnt <= '0;
            r_lo_cnt <= '0;
        end else begin
            r_sync <= {r_sync[0], din};
            if (r_state == S_HIGH) begin
                if (w_din_s) begin
                    if (r_hi_cnt != HI_MAX)
                        r_hi_cnt <= r_hi_cnt + HW'(1);
                end else begin
                    r_state  <= S_LOW;
                    r_lo_cnt <= LW'(1);
                end
            end else begin
                if (w_din_s) begin
                    r_state  <= S_HIGH;
                    r_hi_cnt <= HW'(1);
                end else begin
                    if (r_lo_cnt != LO_MAX)
                        r_lo_cnt <= r_lo_cnt + LW'(1);
                    if (w_gap)
                        r_state <= S_IDLE;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_duty    <= '0;
            r_fwd     <= 1'b0;
            r_frame   <= 1'b0;
        end else begin
            r_frame <= 1'b0;
            if (w_fall && (r_bit_cnt < TOTAL_C)) begin
                r_shift   <= {r_shift[TOTAL-2:0], w_bit};
                r_bit_cnt <= r_bit_cnt + CW'(1);
                if (r_bit_cnt == TOTAL_C - CW'(1))
                    r_fwd <= 1'b1;
            end
            if (w_gap) begin
                r_bit_cnt <= '0;
                if (w_full) begin
                    r_duty  <= r_shift;
                    r_frame <= 1'b1;
                    r_fwd   <= 1'b0;
                end
            end
        end
    end

    // fwd only toggles while din_s is low, so forwarded pulses are always whole.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_dout <= 1'b0;
        else
            r_dout <= r_fwd & w_din_s;
    end

    assign dout  = r_dout;
    assign frame = r_frame;

`ifdef TRAIN_LED_CHAIN_PWM_EN
    logic [BITS-1:0] r_pwm_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_pwm_cnt <= '0;
        else
            r_pwm_cnt <= r_pwm_cnt + BITS'(1);
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_led
        assign led[g] = (r_duty[(NUM_CH-1-g)*BITS +: BITS] > r_pwm_cnt);
    end
`else
    for (genvar g = 0; g < NUM_CH; g++) begin : g_led
        assign led[g] = r_duty[(NUM_CH-1-g)*BITS + BITS-1];
    end
`endif

endmodule

// File: tb/tb_train_led_chain.sv
// tb/tb_train_led_chain.sv - self-checking bench for train_led_chain (default build)
module tb_train_led_chain;
    localparam int NUM_CH = 3;
    localparam int BITS   = 8;
    localparam int TOTAL  = NUM_CH * BITS;
    localparam int LOGN   = 20000;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        din   = 1'b0;
    logic        dout;
    logic [2:0]  led;
    logic        frame;

    always #5 clk = ~clk;

    train_led_chain #(
        .NUM_CH(NUM_CH), .BITS(BITS), .T1_MIN(6), .RESET_CYCLES(64)
    ) dut (
        .clk(clk), .rst_n(rst_n), .din(din), .dout(dout), .led(led), .frame(frame)
    );

    int n_cmp = 0;
    int n_err = 0;
    int frame_cnt = 0;

    bit din_log  [LOGN];
    bit dout_log [LOGN];
    int pidx_log [LOGN];
    int ncyc = 0;
    int pcount = 0;
    bit track = 0;
    bit prev_din = 0;

    // Per-cycle log: din/dout samples plus which pulse of the tracked frame each high sample belongs to.
    always @(negedge clk) begin
        if (frame) frame_cnt++;
        if (ncyc < LOGN) begin
            din_log[ncyc]  = din;
            dout_log[ncyc] = dout;
            if (!track) pcount = 0;
            else if (din && !prev_din) pcount++;
            pidx_log[ncyc] = (track && din) ? pcount - 1 : -1;
        end
        prev_din = din;
        ncyc++;
    end

    typedef struct {
        logic [23:0] val;
        logic [2:0]  led;
    } vec_t;
    vec_t tbl[5];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input int n);
        repeat (n) begin
            @(posedge clk);
            #1 din = v;
        end
    endtask

    task automatic send(input logic [31:0] v, input int nbits, input int w1, input int w0);
        for (int i = nbits - 1; i >= 0; i--) begin
            drive(1'b1, v[i] ? w1 : w0);
            drive(1'b0, 4);
        end
    endtask

    function automatic logic [2:0] model_led(input logic [23:0] v);
        logic [2:0] r;
        for (int c = 0; c < NUM_CH; c++)
            r[c] = v[TOTAL - 1 - c * BITS];
        return r;
    endfunction

    task automatic full_frame(input string name, input logic [23:0] v, input int w1, input int w0);
        int f0;
        f0 = frame_cnt;
        send({8'h00, v}, TOTAL, w1, w0);
        drive(1'b0, 70);
        chk({name, " frame"}, 64'(frame_cnt - f0), 64'd1);
        chk({name, " led"},   64'(led), 64'(model_led(v)));
        chk({name, " duty"},  64'(dut.r_duty), 64'(v));
    endtask

    initial begin
        logic [23:0] v;
        logic [23:0] last;
        int f0, t0, t1, mism, rises, highs;

        tbl[0] = '{24'hFF8000, 3'b011};
        tbl[1] = '{24'h000000, 3'b000};
        tbl[2] = '{24'h800080, 3'b101};
        tbl[3] = '{24'h7F7F7F, 3'b000};
        tbl[4] = '{24'h01C0FF, 3'b110};

        repeat (3) @(posedge clk);
        #1;
        chk("reset dout",  64'(dout),  64'd0);
        chk("reset led",   64'(led),   64'd0);
        chk("reset frame", 64'(frame), 64'd0);
        @(negedge clk) rst_n = 1'b1;
        drive(1'b0, 5);

        for (int i = 0; i < 5; i++) begin
            f0 = frame_cnt;
            send({8'h00, tbl[i].val}, TOTAL, 8, 3);
            drive(1'b0, 70);
            chk($sformatf("tbl%0d frame", i), 64'(frame_cnt - f0), 64'd1);
            chk($sformatf("tbl%0d led", i),   64'(led), 64'(tbl[i].led));
            chk($sformatf("tbl%0d duty", i),  64'(dut.r_duty), 64'(tbl[i].val));
        end

        for (int i = 0; i < 6; i++) begin
            v = 24'($urandom);
            full_frame($sformatf("rand%0d", i), v, 8, 3);
        end

        full_frame("t1_edge", 24'hA5C33C, 6, 5);
        last = 24'hA5C33C;

        f0 = frame_cnt;
        send(32'hFFF, 12, 8, 3);
        drive(1'b0, 70);
        chk("partial frame", 64'(frame_cnt - f0), 64'd0);
        chk("partial led",   64'(led), 64'(model_led(last)));
        chk("partial duty",  64'(dut.r_duty), 64'(last));
        full_frame("after_partial", 24'h5A0FF0, 8, 3);

        v = 24'hC3A55A;
        f0 = frame_cnt;
        send({8'h00, v} >> 13, 11, 8, 3);
        drive(1'b0, 40);
        chk("short gap frame", 64'(frame_cnt - f0), 64'd0);
        send({8'h00, v}, 13, 8, 3);
        drive(1'b0, 70);
        chk("split frame", 64'(frame_cnt - f0), 64'd1);
        chk("split duty",  64'(dut.r_duty), 64'(v));
        chk("split led",   64'(led), 64'(model_led(v)));

        track = 1'b1;
        t0 = ncyc;
        send({24'hFF8000, 8'hA5}, 32, 8, 3);
        drive(1'b0, 70);
        t1 = ncyc;
        track = 1'b0;
        chk("fwd duty", 64'(dut.r_duty), 64'h00FF8000);
        chk("fwd led",  64'(led), 64'b011);
        mism = 0; rises = 0; highs = 0;
        if (t1 < LOGN) begin
            for (int j = t0 + 3; j < t1; j++) begin
                bit e;
                e = (pidx_log[j-3] >= TOTAL) ? din_log[j-3] : 1'b0;
                if (dout_log[j] != e) mism++;
                if (dout_log[j]) highs++;
                if (dout_log[j] && !dout_log[j-1]) rises++;
            end
        end else begin
            mism = -1;
        end
        chk("dout wave",   64'(mism),  64'd0);
        chk("dout pulses", 64'(rises), 64'd8);
        chk("dout highs",  64'(highs), 64'd44);

        send(32'h00007FFF, 15, 8, 3);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #2;
        chk("mid reset led",   64'(led),   64'd0);
        chk("mid reset dout",  64'(dout),  64'd0);
        chk("mid reset frame", 64'(frame), 64'd0);
        chk("mid reset duty",  64'(dut.r_duty), 64'd0);
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        drive(1'b0, 5);
        full_frame("post_reset", 24'h3CFF81, 8, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
